// File: rtl/disp_pkg.sv
// ============================================================================
// disp_pkg : shared constants for the eight-digit hex display multiplexer
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int c_num_digits = 8;
  localparam logic [7:0] c_blank = 8'hFF;

  // Active-low g..a patterns, entry 15 first down to entry 0.
  localparam logic [15:0][6:0] c_seg_pat = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/hex_to_sseg.sv
// ============================================================================
// hex_to_sseg : nibble to active-low seven-segment pattern (g..a)
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module hex_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = c_seg_pat[i_nibble];

endmodule

`default_nettype wire

// File: rtl/disp_mux_hex.sv
// ============================================================================
// disp_mux_hex : time-multiplexed 8-digit hex display, frame-synchronous update
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module disp_mux_hex
  import disp_pkg::*;
#(
  parameter int unsigned DIV = 100_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [31:0] hex_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_tick,
  output logic        upd_pending
);

  localparam int unsigned c_cnt_w = $clog2(DIV);
  localparam int unsigned c_idx_w = $clog2(c_num_digits);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(c_num_digits - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_idx_w-1:0] r_idx;
  logic [31:0]        r_hex_sh, r_hex_act;
  logic [7:0]         r_dp_sh, r_dp_act;
  logic [7:0]         r_blank_sh, r_blank_act;
  logic               r_pend;
  logic [7:0]         r_an, r_sseg;
  logic               r_tick;

  logic               w_step, w_frame;
  logic [c_idx_w-1:0] w_idx_nxt;
  logic [31:0]        w_hex_act_nxt;
  logic [7:0]         w_dp_act_nxt, w_blank_act_nxt;
  logic [7:0]         w_lz_mask;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg;
  logic               w_dark;

  assign w_step    = (r_cnt == c_cnt_max);
  assign w_frame   = w_step && (r_idx == c_idx_max);
  assign w_idx_nxt = w_step ? r_idx + 1'b1 : r_idx;

  // A write landing on the boundary bypasses the shadow and takes effect now.
  always_comb begin
    w_hex_act_nxt   = r_hex_act;
    w_dp_act_nxt    = r_dp_act;
    w_blank_act_nxt = r_blank_act;
    if (w_frame) begin
      if (wr) begin
        w_hex_act_nxt   = hex_in;
        w_dp_act_nxt    = dp_in;
        w_blank_act_nxt = blank_in;
      end else if (r_pend) begin
        w_hex_act_nxt   = r_hex_sh;
        w_dp_act_nxt    = r_dp_sh;
        w_blank_act_nxt = r_blank_sh;
      end
    end
  end

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_lz_mask = '0;
    for (int k = 1; k < c_num_digits; k++)
      w_lz_mask[k] = lz_en && ((w_hex_act_nxt >> (4 * k)) == 32'd0);
  end

  assign w_nib  = w_hex_act_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_dark = w_blank_act_nxt[w_idx_nxt] | w_lz_mask[w_idx_nxt];

  hex_to_sseg u_hex_to_sseg (
    .i_nibble (w_nib),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_hex_sh    <= '0;
      r_dp_sh     <= '0;
      r_blank_sh  <= c_blank;
      r_hex_act   <= '0;
      r_dp_act    <= '0;
      r_blank_act <= c_blank;
      r_pend      <= 1'b0;
      r_an        <= 8'hFF;
      r_sseg      <= c_blank;
      r_tick      <= 1'b0;
    end else begin
      r_cnt       <= w_step ? '0 : r_cnt + 1'b1;
      r_idx       <= w_idx_nxt;
      r_hex_act   <= w_hex_act_nxt;
      r_dp_act    <= w_dp_act_nxt;
      r_blank_act <= w_blank_act_nxt;
      if (wr) begin
        r_hex_sh   <= hex_in;
        r_dp_sh    <= dp_in;
        r_blank_sh <= blank_in;
      end
      if (w_frame)
        r_pend <= 1'b0;
      else if (wr)
        r_pend <= 1'b1;
      r_an   <= ~(8'd1 << w_idx_nxt);
      r_sseg <= w_dark ? c_blank : {~w_dp_act_nxt[w_idx_nxt], w_seg};
      r_tick <= w_frame;
    end
  end

  assign an          = r_an;
  assign sseg        = r_sseg;
  assign frame_tick  = r_tick;
  assign upd_pending = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_disp_mux_hex.sv
// ============================================================================
// tb_disp_mux_hex : randomized and directed bench with a frame-level model
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module tb_disp_mux_hex;

  localparam int unsigned DIV   = 4;
  localparam int          FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] hex_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  an, sseg;
  logic        frame_tick, upd_pending;

  int checks = 0;
  int failures = 0;

  // Model: edges since reset release, plus displayed and waiting frame data.
  int          e;
  logic [31:0] m_hex, m_hex_w;
  logic [7:0]  m_dp, m_dp_w, m_bl, m_bl_w;
  bit          m_pend;

  disp_mux_hex #(.DIV(DIV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr          (wr),
    .hex_in      (hex_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_en       (lz_en),
    .an          (an),
    .sseg        (sseg),
    .frame_tick  (frame_tick),
    .upd_pending (upd_pending)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  function automatic logic [7:0] exp_sseg(input int d);
    int top = 0;
    for (int k = 0; k < 8; k++)
      if (((m_hex >> (4 * k)) & 32'hF) != 0) top = k;
    if (m_bl[d] || (lz_en && d > top)) return 8'hFF;
    return glyph(4'((m_hex >> (4 * d)) & 32'hF)) & (m_dp[d] ? 8'h7F : 8'hFF);
  endfunction

  task automatic model_reset();
    e = 0; m_pend = 0;
    m_hex = '0; m_dp = '0; m_bl = 8'hFF;
    m_hex_w = '0; m_dp_w = '0; m_bl_w = 8'hFF;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    int d;
    @(posedge clk);
    e++;
    if (wr) begin
      m_hex_w = hex_in; m_dp_w = dp_in; m_bl_w = blank_in; m_pend = 1;
    end
    if (e % FRAME == 0) begin
      if (m_pend) begin m_hex = m_hex_w; m_dp = m_dp_w; m_bl = m_bl_w; end
      m_pend = 0;
    end
    d = (e / DIV) % 8;
    #1;
    chk_eq("an", an, ~(32'd1 << d) & 32'hFF);
    chk_eq("sseg", sseg, exp_sseg(d));
    chk_eq("frame_tick", frame_tick, (e % FRAME == 0) ? 1 : 0);
    chk_eq("upd_pending", upd_pending, m_pend);
    wr = 1'b0;
  endtask

  task automatic run_to(input int m);
    for (int i = 0; i < FRAME + 1; i++) begin
      if (e % FRAME == m) break;
      step();
    end
  endtask

  task automatic write(input logic [31:0] h, input logic [7:0] dp, input logic [7:0] bl);
    hex_in = h; dp_in = dp; blank_in = bl; wr = 1'b1;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk_eq("rst_an", an, 8'hFF);
    chk_eq("rst_sseg", sseg, 8'hFF);
    chk_eq("rst_tick", frame_tick, 0);
    chk_eq("rst_pend", upd_pending, 0);
    @(posedge clk);
    #2;
    wr = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Scan order and frame tick from reset, all digits dark.
    step();
    chk_eq("first_an", an, 8'hFE);
    for (int i = 0; i < 2 * FRAME + 8; i++) step();

    // Mid-frame write held until the boundary.
    run_to(10);
    write(32'h0123_ABCD, 8'h00, 8'h00);
    chk_eq("pend_set", upd_pending, 1);
    run_to(0);
    chk_eq("new_d0", sseg, 8'hA1);
    chk_eq("pend_clr", upd_pending, 0);
    run_to(16);
    chk_eq("new_d4", sseg, 8'hB0);
    run_to(20);
    chk_eq("new_d5", sseg, 8'hA4);

    // Last write in a frame wins.
    run_to(5);
    write(32'h1111_1111, 8'h00, 8'h00);
    run_to(12);
    write(32'h2222_2222, 8'h00, 8'h00);
    run_to(0);
    chk_eq("last_d0", sseg, 8'hA4);
    run_to(28);
    chk_eq("last_d7", sseg, 8'hA4);

    // Write in the boundary cycle.
    run_to(FRAME - 1);
    write(32'h89AB_CDEF, 8'h00, 8'h00);
    chk_eq("bnd_pend", upd_pending, 0);
    chk_eq("bnd_tick", frame_tick, 1);
    chk_eq("bnd_d0", sseg, 8'h8E);

    // Leading-zero suppression.
    lz_en = 1'b1;
    run_to(3);
    write(32'h0000_0050, 8'h00, 8'h00);
    run_to(0);
    chk_eq("lz_d0", sseg, 8'hC0);
    run_to(4);
    chk_eq("lz_d1", sseg, 8'h92);
    run_to(8);
    chk_eq("lz_d2", sseg, 8'hFF);
    run_to(28);
    chk_eq("lz_d7", sseg, 8'hFF);
    lz_en = 1'b0;
    step();
    chk_eq("nolz_d7", sseg, 8'hC0);

    // Decimal point, blank mask, then reset mid-frame with data pending.
    run_to(10);
    write(32'h1234_5670, 8'h01, 8'h80);
    run_to(0);
    chk_eq("dp_d0", sseg, 8'h40);
    run_to(28);
    chk_eq("blank_d7", sseg, 8'hFF);
    run_to(14);
    write(32'hFFFF_FFFF, 8'hFF, 8'h00);
    do_reset();
    step();
    chk_eq("rst2_an", an, 8'hFE);
    chk_eq("rst2_sseg", sseg, 8'hFF);
    for (int i = 0; i < FRAME + 4; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 9) == 0) begin
        hex_in   = $urandom >> (4 * $urandom_range(0, 7));
        dp_in    = 8'($urandom);
        blank_in = 8'($urandom) & 8'($urandom);
        wr       = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
